// File: rtl/multi_wave_gen_pkg.sv
// Shared types for the multi-channel waveform generator.
package multi_wave_gen_pkg;

   typedef enum logic [1:0] {
      WAVE_SAW     = 2'd0,
      WAVE_TRI     = 2'd1,
      WAVE_SQR     = 2'd2,
      WAVE_RAMP_DN = 2'd3
   } wave_mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } gen_state_e;

endpackage

// File: rtl/multi_wave_gen_if.sv
// Sample stream from the waveform generator to the mixer/DAC path.
interface multi_wave_gen_if #(
   parameter int width_p    = 12,
   parameter int channels_p = 4
);
   localparam int chan_w_p = $clog2(channels_p);

   logic [width_p-1:0]  data_o;
   logic [chan_w_p-1:0] chan_o;
   logic                valid_o;
   logic                ready_i;

   modport master (output data_o, chan_o, valid_o, input ready_i);
   modport slave  (input data_o, chan_o, valid_o, output ready_i);
endinterface

// File: rtl/wave_shaper.sv
// Combinational sample shaper: top phase bits + mode + enable -> unsigned sample.
module wave_shaper
   import multi_wave_gen_pkg::*;
#(
   parameter int width_p = 12
) (
   input  logic [width_p-1:0] p,
   input  wave_mode_e         mode,
   input  logic               en,
   output logic [width_p-1:0] sample
);

   logic [width_p-1:0] tri_v;

   always_comb begin
      tri_v  = {p[width_p-2:0], 1'b0};
      sample = '0;
      if (en) begin
         case (mode)
            WAVE_SAW:     sample = p;
            WAVE_TRI:     sample = p[width_p-1] ? ~tri_v : tri_v;
            WAVE_SQR:     sample = p[width_p-1] ? '0 : '1;
            WAVE_RAMP_DN: sample = ~p;
            default:      sample = '0;
         endcase
      end
   end

endmodule

// File: rtl/multi_wave_gen.sv
// Multi-channel phase-accumulator waveform generator; one sample per channel per tick.
//
// state   | meaning
// ST_IDLE | waiting for tick_i; output register idle
// ST_EMIT | presenting channel idx_q; advance on handshake, return after last channel
module multi_wave_gen
   import multi_wave_gen_pkg::*;
#(
   parameter int  width_p       = 12,
   parameter int  phase_width_p = 16,
   parameter int  channels_p    = 4,
   localparam int chan_w_p      = $clog2(channels_p)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     tick_i,
   input  logic                     cfg_we_i,
   input  logic [chan_w_p-1:0]      cfg_chan_i,
   input  logic [phase_width_p-1:0] cfg_inc_i,
   input  logic [1:0]               cfg_mode_i,
   input  logic                     cfg_en_i,
   input  logic                     cfg_clr_i,
   output logic                     overrun_o,
   multi_wave_gen_if.master         strm
);

   localparam logic [chan_w_p-1:0] last_idx_c = chan_w_p'(channels_p - 1);

   gen_state_e state_q, state_d;

   logic [chan_w_p-1:0]      idx_q;
   logic [chan_w_p-1:0]      sel_chan;
   logic                     last;
   logic                     hs;
   logic                     load;

   logic [phase_width_p-1:0] phase_q [channels_p];
   logic [phase_width_p-1:0] inc_q   [channels_p];
   wave_mode_e               mode_q  [channels_p];
   logic                     en_q    [channels_p];

   logic [phase_width_p-1:0] sel_phase;
   logic [width_p-1:0]       shaped;

   logic [width_p-1:0]       data_q;
   logic [chan_w_p-1:0]      chan_q;
   logic                     valid_q;
   logic                     overrun_q;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (tick_i)     state_d = ST_EMIT;
         ST_EMIT: if (hs && last) state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   // The shaper always looks at the channel that the next load would present.
   always_comb begin
      last     = (idx_q == last_idx_c);
      hs       = (state_q == ST_EMIT) && valid_q && strm.ready_i;
      load     = ((state_q == ST_IDLE) && tick_i) || (hs && !last);
      sel_chan = ((state_q == ST_IDLE) || last) ? '0 : idx_q + 1'b1;
   end

   assign sel_phase = phase_q[sel_chan];

   wave_shaper #(.width_p(width_p)) u_shaper (
      .p      (sel_phase[phase_width_p-1 -: width_p]),
      .mode   (mode_q[sel_chan]),
      .en     (en_q[sel_chan]),
      .sample (shaped)
   );

   // A config write to the channel being advanced lands last, so a clear beats the increment.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < channels_p; i++) begin
            phase_q[i] <= '0;
            inc_q[i]   <= '0;
            mode_q[i]  <= WAVE_SAW;
            en_q[i]    <= 1'b0;
         end
      end else begin
         for (int i = 0; i < channels_p; i++) begin
            if (hs && (idx_q == chan_w_p'(i)) && en_q[i])
               phase_q[i] <= phase_q[i] + inc_q[i];
            if (cfg_we_i && (cfg_chan_i == chan_w_p'(i))) begin
               inc_q[i]  <= cfg_inc_i;
               mode_q[i] <= wave_mode_e'(cfg_mode_i);
               en_q[i]   <= cfg_en_i;
               if (cfg_clr_i) phase_q[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         idx_q     <= '0;
         data_q    <= '0;
         chan_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (load) begin
            idx_q   <= sel_chan;
            data_q  <= shaped;
            chan_q  <= sel_chan;
            valid_q <= 1'b1;
         end else if (hs && last) begin
            valid_q <= 1'b0;
         end
         if (tick_i && (state_q == ST_EMIT)) overrun_q <= 1'b1;
      end
   end

   assign strm.data_o  = data_q;
   assign strm.chan_o  = chan_q;
   assign strm.valid_o = valid_q;
   assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_multi_wave_gen.sv
// Self-checking bench for multi_wave_gen against an arithmetic per-channel model.
module tb_multi_wave_gen;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        tick_i;
   logic        cfg_we_i;
   logic [1:0]  cfg_chan_i;
   logic [15:0] cfg_inc_i;
   logic [1:0]  cfg_mode_i;
   logic        cfg_en_i;
   logic        cfg_clr_i;
   logic        overrun_o;

   multi_wave_gen_if #(.width_p(12), .channels_p(4)) strm ();

   multi_wave_gen #(.width_p(12), .phase_width_p(16), .channels_p(4)) dut (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .tick_i     (tick_i),
      .cfg_we_i   (cfg_we_i),
      .cfg_chan_i (cfg_chan_i),
      .cfg_inc_i  (cfg_inc_i),
      .cfg_mode_i (cfg_mode_i),
      .cfg_en_i   (cfg_en_i),
      .cfg_clr_i  (cfg_clr_i),
      .overrun_o  (overrun_o),
      .strm       (strm)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   int unsigned m_phase [4];
   int unsigned m_inc   [4];
   int          m_mode  [4];
   bit          m_en    [4];

   function automatic logic [11:0] ref_sample(int ch);
      int p;
      int r;
      p = int'((m_phase[ch] >> 4) & 32'hFFF);
      if (!m_en[ch])          r = 0;
      else if (m_mode[ch] == 0) r = p;
      else if (m_mode[ch] == 1) r = (p < 2048) ? 2 * p : 4095 - 2 * (p - 2048);
      else if (m_mode[ch] == 2) r = (p < 2048) ? 4095 : 0;
      else                    r = 4095 - p;
      return 12'(r);
   endfunction

   function automatic void model_advance(int ch);
      if (m_en[ch]) m_phase[ch] = (m_phase[ch] + m_inc[ch]) & 32'hFFFF;
   endfunction

   function automatic void model_write(int ch, int unsigned inc, int mode, bit en, bit clr);
      m_inc[ch]  = inc;
      m_mode[ch] = mode;
      m_en[ch]   = en;
      if (clr) m_phase[ch] = 0;
   endfunction

   function automatic void model_zero();
      for (int i = 0; i < 4; i++) begin
         m_phase[i] = 0; m_inc[i] = 0; m_mode[i] = 0; m_en[i] = 0;
      end
   endfunction

   task automatic do_reset();
      reset_n_i = 1'b0;
      tick_i = 1'b0; cfg_we_i = 1'b0; strm.ready_i = 1'b1;
      model_zero();
      @(posedge clk_i); #1;
      reset_n_i = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic cfg_write(int ch, int unsigned inc, int mode, bit en, bit clr);
      cfg_we_i = 1'b1; cfg_chan_i = 2'(ch); cfg_inc_i = 16'(inc);
      cfg_mode_i = 2'(mode); cfg_en_i = en; cfg_clr_i = clr;
      @(posedge clk_i); #1;
      cfg_we_i = 1'b0; cfg_clr_i = 1'b0;
      model_write(ch, inc, mode, en, clr);
   endtask

   // Starts one round and records the accepted beats; ready is optionally randomized.
   task automatic run_round(input bit rnd_ready, output logic [11:0] d [4], output int c [4], output int nb);
      for (int k = 0; k < 4; k++) begin d[k] = '0; c[k] = -1; end
      tick_i = 1'b1;
      @(posedge clk_i); #1;
      tick_i = 1'b0;
      nb = 0;
      for (int cyc = 0; cyc < 40 && nb < 4; cyc++) begin
         strm.ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (strm.valid_o && strm.ready_i) begin
            d[nb] = strm.data_o;
            c[nb] = int'(strm.chan_o);
            model_advance(int'(strm.chan_o));
            nb++;
         end
         @(posedge clk_i); #1;
      end
      strm.ready_i = 1'b1;
   endtask

   task automatic test_reset();
      logic [11:0] d [4]; int c [4]; int nb;
      n_checks++; if (strm.valid_o !== 1'b0) $display("FAIL rst_init_valid got %b exp 0", strm.valid_o); else n_pass++;
      n_checks++; if (overrun_o !== 1'b0) $display("FAIL rst_init_overrun got %b exp 0", overrun_o); else n_pass++;
      cfg_write(0, 0, 3, 1, 0);
      cfg_write(1, 0, 3, 1, 0);
      tick_i = 1'b1; @(posedge clk_i); #1; tick_i = 1'b0;
      n_checks++; if (strm.valid_o !== 1'b1 || strm.chan_o !== 2'd0 || strm.data_o !== 12'hFFF)
         $display("FAIL rst_first_beat got v=%b ch=%0d d=%h exp v=1 ch=0 d=fff", strm.valid_o, strm.chan_o, strm.data_o); else n_pass++;
      tick_i = 1'b1; @(posedge clk_i); #1; tick_i = 1'b0;
      n_checks++; if (overrun_o !== 1'b1 || strm.chan_o !== 2'd1)
         $display("FAIL rst_pre_overrun got ov=%b ch=%0d exp ov=1 ch=1", overrun_o, strm.chan_o); else n_pass++;
      reset_n_i = 1'b0;
      #1;
      n_checks++; if (strm.valid_o !== 1'b0) $display("FAIL rst_async_valid got %b exp 0", strm.valid_o); else n_pass++;
      n_checks++; if (strm.data_o !== 12'h000) $display("FAIL rst_async_data got %h exp 000", strm.data_o); else n_pass++;
      n_checks++; if (strm.chan_o !== 2'd0) $display("FAIL rst_async_chan got %0d exp 0", strm.chan_o); else n_pass++;
      n_checks++; if (overrun_o !== 1'b0) $display("FAIL rst_async_overrun got %b exp 0", overrun_o); else n_pass++;
      model_zero();
      @(posedge clk_i); #1;
      reset_n_i = 1'b1;
      @(posedge clk_i); #1;
      run_round(1'b0, d, c, nb);
      n_checks++; if (nb !== 4) $display("FAIL rst_round_beats got %0d exp 4", nb); else n_pass++;
      n_checks++; if (d[0] !== 12'h000 || c[0] !== 0) $display("FAIL rst_round_ch0 got d=%h ch=%0d exp d=000 ch=0", d[0], c[0]); else n_pass++;
   endtask

   task automatic test_saw();
      logic [11:0] d [4]; int c [4]; int nb;
      logic [11:0] exp;
      cfg_write(0, 32'h1000, 0, 1, 0);
      for (int i = 0; i < 17; i++) begin
         exp = 12'((i % 16) * 256);
         run_round(1'b0, d, c, nb);
         n_checks++; if (nb !== 4) $display("FAIL saw_beats[%0d] got %0d exp 4", i, nb); else n_pass++;
         n_checks++; if (d[0] !== exp) $display("FAIL saw_ch0[%0d] got %h exp %h", i, d[0], exp); else n_pass++;
         n_checks++; if (strm.valid_o !== 1'b0) $display("FAIL saw_valid_drop[%0d] got %b exp 0", i, strm.valid_o); else n_pass++;
         if (i == 0) begin
            for (int k = 0; k < 4; k++) begin
               n_checks++; if (c[k] !== k) $display("FAIL saw_chan_order[%0d] got %0d exp %0d", k, c[k], k); else n_pass++;
            end
            n_checks++; if (d[1] !== 0 || d[2] !== 0 || d[3] !== 0)
               $display("FAIL saw_disabled got %h %h %h exp 000 000 000", d[1], d[2], d[3]); else n_pass++;
         end
         repeat (3) begin @(posedge clk_i); #1; end
      end
   endtask

   task automatic test_triangle();
      logic [11:0] d [4]; int c [4]; int nb;
      logic [11:0] tri_tbl [9];
      logic [11:0] e0;
      tri_tbl = '{12'h000, 12'h400, 12'h800, 12'hC00, 12'hFFF, 12'hBFF, 12'h7FF, 12'h3FF, 12'h000};
      cfg_write(1, 32'h2000, 1, 1, 0);
      for (int i = 0; i < 9; i++) begin
         e0 = ref_sample(0);
         run_round(1'b0, d, c, nb);
         n_checks++; if (d[1] !== tri_tbl[i]) $display("FAIL tri_ch1[%0d] got %h exp %h", i, d[1], tri_tbl[i]); else n_pass++;
         n_checks++; if (d[0] !== e0) $display("FAIL tri_ch0[%0d] got %h exp %h", i, d[0], e0); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [11:0] d [4]; int c [4]; int nb;
      logic [11:0] e [4];
      int stalls, vcyc;
      cfg_write(2, 32'h0800, 0, 1, 1);
      for (int k = 0; k < 4; k++) e[k] = ref_sample(k);
      tick_i = 1'b1; @(posedge clk_i); #1; tick_i = 1'b0;
      stalls = 0; vcyc = 0; nb = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (!strm.valid_o) break;
         vcyc++;
         if (strm.chan_o == 2'd2 && stalls < 3) begin
            strm.ready_i = 1'b0;
            n_checks++; if (strm.data_o !== e[2] || strm.chan_o !== 2'd2)
               $display("FAIL bp_hold[%0d] got d=%h ch=%0d exp d=%h ch=2", stalls, strm.data_o, strm.chan_o, e[2]); else n_pass++;
            stalls++;
         end else begin
            strm.ready_i = 1'b1;
            n_checks++; if (strm.data_o !== e[nb] || int'(strm.chan_o) !== nb)
               $display("FAIL bp_beat[%0d] got d=%h ch=%0d exp d=%h ch=%0d", nb, strm.data_o, strm.chan_o, e[nb], nb); else n_pass++;
            model_advance(nb);
            nb++;
         end
         @(posedge clk_i); #1;
      end
      strm.ready_i = 1'b1;
      n_checks++; if (vcyc !== 7) $display("FAIL bp_round_len got %0d exp 7", vcyc); else n_pass++;
      n_checks++; if (nb !== 4) $display("FAIL bp_beats got %0d exp 4", nb); else n_pass++;
      run_round(1'b0, d, c, nb);
      n_checks++; if (d[2] !== 12'h080) $display("FAIL bp_ch2_next got %h exp 080", d[2]); else n_pass++;
   endtask

   task automatic test_clear_config();
      logic [11:0] d [4]; int c [4]; int nb;
      logic [11:0] e [4];
      logic [11:0] e2_next;
      int ch;
      for (int k = 0; k < 4; k++) e[k] = ref_sample(k);
      tick_i = 1'b1; @(posedge clk_i); #1; tick_i = 1'b0;
      nb = 0;
      for (int cyc = 0; cyc < 40 && nb < 4; cyc++) begin
         strm.ready_i = 1'b1;
         cfg_we_i = 1'b0; cfg_clr_i = 1'b0;
         if (strm.valid_o) begin
            ch = int'(strm.chan_o);
            n_checks++; if (strm.data_o !== e[nb] || ch !== nb)
               $display("FAIL cc_beat[%0d] got d=%h ch=%0d exp d=%h ch=%0d", nb, strm.data_o, ch, e[nb], nb); else n_pass++;
            model_advance(ch);
            if (ch == 0) begin
               cfg_we_i = 1'b1; cfg_chan_i = 2'd0; cfg_inc_i = 16'h1000;
               cfg_mode_i = 2'd3; cfg_en_i = 1'b1; cfg_clr_i = 1'b1;
               model_write(0, 32'h1000, 3, 1, 1);
            end else if (ch == 1) begin
               cfg_we_i = 1'b1; cfg_chan_i = 2'd2; cfg_inc_i = 16'h0800;
               cfg_mode_i = 2'd2; cfg_en_i = 1'b1; cfg_clr_i = 1'b0;
               model_write(2, 32'h0800, 2, 1, 0);
            end
            nb++;
         end
         @(posedge clk_i); #1;
      end
      cfg_we_i = 1'b0; cfg_clr_i = 1'b0;
      n_checks++; if (nb !== 4) $display("FAIL cc_beats got %0d exp 4", nb); else n_pass++;
      e2_next = ref_sample(2);
      run_round(1'b0, d, c, nb);
      n_checks++; if (d[0] !== 12'hFFF) $display("FAIL cc_clear_ch0 got %h exp fff", d[0]); else n_pass++;
      n_checks++; if (d[2] !== e2_next) $display("FAIL cc_mode_ch2 got %h exp %h", d[2], e2_next); else n_pass++;
   endtask

   task automatic test_random();
      logic [11:0] d [4]; int c [4]; int nb;
      logic [11:0] e [4];
      for (int r = 0; r < 20; r++) begin
         cfg_write(int'($urandom_range(0, 3)), $urandom_range(0, 16'hFFFF), int'($urandom_range(0, 3)),
                   bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) == 0));
         for (int k = 0; k < 4; k++) e[k] = ref_sample(k);
         run_round(1'b1, d, c, nb);
         n_checks++; if (nb !== 4) $display("FAIL rnd_beats[%0d] got %0d exp 4", r, nb); else n_pass++;
         for (int k = 0; k < 4; k++) begin
            n_checks++; if (d[k] !== e[k] || c[k] !== k)
               $display("FAIL rnd_beat[%0d][%0d] got d=%h ch=%0d exp d=%h ch=%0d", r, k, d[k], c[k], e[k], k); else n_pass++;
         end
      end
   endtask

   task automatic test_overrun_disable();
      logic [11:0] d [4]; int c [4]; int nb;
      logic [11:0] e [4];
      int vcyc;
      n_checks++; if (overrun_o !== 1'b0) $display("FAIL ov_clean_before got %b exp 0", overrun_o); else n_pass++;
      for (int k = 0; k < 4; k++) e[k] = ref_sample(k);
      tick_i = 1'b1; @(posedge clk_i); #1; tick_i = 1'b0;
      nb = 0; vcyc = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         tick_i = (cyc == 1);
         if (strm.valid_o) begin
            vcyc++;
            n_checks++; if (strm.data_o !== e[nb] || int'(strm.chan_o) !== nb)
               $display("FAIL ov_beat[%0d] got d=%h ch=%0d exp d=%h ch=%0d", nb, strm.data_o, strm.chan_o, e[nb], nb); else n_pass++;
            model_advance(nb);
            nb++;
         end
         @(posedge clk_i); #1;
      end
      tick_i = 1'b0;
      n_checks++; if (vcyc !== 4) $display("FAIL ov_no_restart got %0d valid cycles exp 4", vcyc); else n_pass++;
      n_checks++; if (overrun_o !== 1'b1) $display("FAIL ov_set got %b exp 1", overrun_o); else n_pass++;

      cfg_write(3, 32'h3000, 0, 1, 1);
      run_round(1'b0, d, c, nb);
      n_checks++; if (d[3] !== 12'h000) $display("FAIL dis_ch3_start got %h exp 000", d[3]); else n_pass++;
      cfg_write(3, 32'h3000, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         run_round(1'b0, d, c, nb);
         n_checks++; if (d[3] !== 12'h000 || c[3] !== 3) $display("FAIL dis_ch3_zero[%0d] got d=%h ch=%0d exp d=000 ch=3", i, d[3], c[3]); else n_pass++;
      end
      cfg_write(3, 32'h3000, 0, 1, 0);
      run_round(1'b0, d, c, nb);
      n_checks++; if (d[3] !== 12'h300) $display("FAIL dis_ch3_held got %h exp 300", d[3]); else n_pass++;
      n_checks++; if (overrun_o !== 1'b1) $display("FAIL ov_sticky got %b exp 1", overrun_o); else n_pass++;

      do_reset();
      tick_i = 1'b1; @(posedge clk_i); #1; tick_i = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (strm.valid_o && strm.chan_o == 2'd3) begin
            tick_i = 1'b1;
            @(posedge clk_i); #1;
            tick_i = 1'b0;
            break;
         end
         @(posedge clk_i); #1;
      end
      vcyc = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         if (strm.valid_o) vcyc++;
         @(posedge clk_i); #1;
      end
      n_checks++; if (vcyc !== 0) $display("FAIL ov_last_tick_accepted got %0d valid cycles exp 0", vcyc); else n_pass++;
      n_checks++; if (overrun_o !== 1'b1) $display("FAIL ov_last_tick_flag got %b exp 1", overrun_o); else n_pass++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n_i = 1'b0;
      tick_i = 1'b0; cfg_we_i = 1'b0; cfg_chan_i = '0; cfg_inc_i = '0;
      cfg_mode_i = '0; cfg_en_i = 1'b0; cfg_clr_i = 1'b0;
      strm.ready_i = 1'b1;
      model_zero();
      repeat (2) @(posedge clk_i);
      #1;
      reset_n_i = 1'b1;
      @(posedge clk_i); #1;

      test_reset();
      test_saw();
      test_triangle();
      test_backpressure();
      test_clear_config();
      test_random();
      test_overrun_disable();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
